// File: rtl/wb_pkg.sv
// wb_pkg: shared types for the write-back stage and its store queue.
// Entry layout, EFLAGS reset value, store sizes, drain FSM states.
package wb_pkg;

    localparam int PA_W = 32;
    localparam int ST_W = 64;

    localparam logic [31:0] EFLAGS_RST = 32'h0000_0002;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_W = 2'b01,
        SZ_D = 2'b10,
        SZ_Q = 2'b11
    } sz_e;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } drain_e;

    typedef struct packed {
        logic [PA_W-1:0] addr;
        logic [ST_W-1:0] data;
        sz_e             size;
    } stq_entry_t;

endpackage

// File: rtl/wb_stq.sv
// wb_stq: store queue with D-cache drain FSM and load/store overlap check.
// Ports: i_clk/i_rst_n, i_enq+i_enq_entry (tail write), i_ack (head accepted),
// i_rd_v/i_rd_addr (MEM load probe), o_req/o_head (D-cache request),
// o_hit (load overlaps a pending store), o_empty, o_full.
module wb_stq
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_enq,
    input  stq_entry_t      i_enq_entry,
    input  logic            i_ack,
    input  logic [PA_W-1:0] i_rd_addr,
    input  logic            i_rd_v,
    output logic            o_req,
    output stq_entry_t      o_head,
    output logic            o_hit,
    output logic            o_empty,
    output logic            o_full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    stq_entry_t       r_mem [DEPTH];
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    drain_e           r_state;
    logic             r_gap;

    drain_e           w_state_nxt;
    logic [CW-1:0]    w_count_nxt;
    logic             w_req;
    logic             w_deq;
    logic [PW-1:0]    w_off [DEPTH];
    logic [DEPTH-1:0] w_vld;
    logic             w_hit;
    logic             w_unused_lo;

    // r_gap forces one idle request cycle after every ack so the next
    // head is presented from the updated registered pointer.
    assign w_req   = (r_state == ISSUE) & ~r_gap;
    assign w_deq   = w_req & i_ack;
    assign o_req   = w_req;
    assign o_head  = r_mem[r_head];
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));

    assign w_unused_lo = ^i_rd_addr[2:0];

    always_comb begin
        w_count_nxt = r_count;
        unique case ({i_enq, w_deq})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (r_count != '0)
                    w_state_nxt = ISSUE;
            end
            ISSUE: begin
                if (w_deq && r_count == CW'(1))
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Slot i is live when its distance from head is below count; the head
    // being acked this cycle is still live.
    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off[i] = PW'(i) - r_head;
            w_vld[i] = ({1'b0, w_off[i]} < r_count);
            if (w_vld[i] &&
                r_mem[i].addr[PA_W-1:3] == i_rd_addr[PA_W-1:3])
                w_hit = 1'b1;
        end
    end

    assign o_hit = i_rd_v & w_hit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_state <= IDLE;
            r_gap   <= 1'b0;
        end else begin
            if (i_enq) begin
                r_mem[r_tail] <= i_enq_entry;
                r_tail        <= r_tail + PW'(1);
            end
            if (w_deq)
                r_head <= r_head + PW'(1);
            r_count <= w_count_nxt;
            r_state <= w_state_nxt;
            r_gap   <= w_deq;
        end
    end

endmodule

// File: rtl/wb_stage_stq.sv
// wb_stage_stq: write-back stage; commits GPR/EFLAGS, queues stores to D-cache.
// Inputs E2W_* (EX results), M2W_* (load probe), D2W_ack; outputs W2E_stall,
// W2E_eflags, W2R_gpr_*, W2D_* (store request), W2M_stq_hit, W2X_stq_empty,
// W2X_retire_cnt (live only when WB_RETIRE_CNT_EN is defined, else tied 0).
module wb_stage_stq
    import wb_pkg::*;
#(
    parameter int STQ_DEPTH = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              E2W_v,
    input  logic [DATA_W-1:0] E2W_result,
    input  logic [31:0]       E2W_new_eflags,
    input  logic              E2W_load_cc,
    input  logic              E2W_dest_gpr_wt,
    input  logic [2:0]        E2W_dest_gpr_sel,
    input  logic              E2W_mem_wt,
    input  logic [1:0]        E2W_mem_wt_size,
    input  logic [ADDR_W-1:0] E2W_WR_PA1,
    input  logic [ADDR_W-1:0] M2W_rd_addr,
    input  logic              M2W_rd_v,
    input  logic              D2W_ack,
    output logic              W2E_stall,
    output logic [31:0]       W2E_eflags,
    output logic              W2R_gpr_we,
    output logic [2:0]        W2R_gpr_sel,
    output logic [31:0]       W2R_gpr_data,
    output logic              W2D_req,
    output logic [ADDR_W-1:0] W2D_addr,
    output logic [DATA_W-1:0] W2D_data,
    output logic [1:0]        W2D_size,
    output logic              W2M_stq_hit,
    output logic              W2X_stq_empty,
    output logic [31:0]       W2X_retire_cnt
);

    logic       w_full;
    logic       w_acc;
    logic       w_enq;
    stq_entry_t w_entry;
    stq_entry_t w_head;

    logic        r_gpr_we;
    logic [2:0]  r_gpr_sel;
    logic [31:0] r_gpr_data;
    logic [31:0] r_eflags;

    // Stall only on a full queue, never on the cache ack: no comb path back.
    assign W2E_stall = E2W_v & E2W_mem_wt & w_full;
    assign w_acc     = E2W_v & ~W2E_stall;
    assign w_enq     = w_acc & E2W_mem_wt;

    assign w_entry.addr = E2W_WR_PA1;
    assign w_entry.data = E2W_result;
    assign w_entry.size = sz_e'(E2W_mem_wt_size);

    wb_stq #(
        .DEPTH (STQ_DEPTH)
    ) u_stq (
        .i_clk       (CLK),
        .i_rst_n     (CLR),
        .i_enq       (w_enq),
        .i_enq_entry (w_entry),
        .i_ack       (D2W_ack),
        .i_rd_addr   (M2W_rd_addr),
        .i_rd_v      (M2W_rd_v),
        .o_req       (W2D_req),
        .o_head      (w_head),
        .o_hit       (W2M_stq_hit),
        .o_empty     (W2X_stq_empty),
        .o_full      (w_full)
    );

    assign W2D_addr = w_head.addr;
    assign W2D_data = w_head.data;
    assign W2D_size = w_head.size;

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_gpr_we   <= 1'b0;
            r_gpr_sel  <= '0;
            r_gpr_data <= '0;
            r_eflags   <= EFLAGS_RST;
        end else begin
            r_gpr_we <= w_acc & E2W_dest_gpr_wt;
            if (w_acc && E2W_dest_gpr_wt) begin
                r_gpr_sel  <= E2W_dest_gpr_sel;
                r_gpr_data <= E2W_result[31:0];
            end
            if (w_acc && E2W_load_cc)
                r_eflags <= E2W_new_eflags;
        end
    end

    assign W2R_gpr_we   = r_gpr_we;
    assign W2R_gpr_sel  = r_gpr_sel;
    assign W2R_gpr_data = r_gpr_data;
    assign W2E_eflags   = r_eflags;

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] r_retire_cnt;

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR)
            r_retire_cnt <= '0;
        else if (w_acc)
            r_retire_cnt <= r_retire_cnt + 32'd1;
    end

    assign W2X_retire_cnt = r_retire_cnt;
`else
    assign W2X_retire_cnt = 32'h0;
`endif

endmodule
